// File: rtl/cpu_pkg.sv
// Shared core constants: data width, BTB geometry and 2-bit direction counter encodings.
package cpu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned BTB_ENTRIES = 16;
  localparam int unsigned BTB_IDX_W   = 4;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

endpackage

// File: rtl/sat_cnt2.sv
// Combinational next-state of a 2-bit saturating up/down direction counter.
module sat_cnt2
  import cpu_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       up,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (up) begin
      if (cnt != CNT_ST) cnt_next = cnt + 2'b01;
    end else begin
      if (cnt != CNT_SNT) cnt_next = cnt - 2'b01;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped flop-based BTB: zero-latency lookup for IF, registered training from EX.
module btb_predictor
  import cpu_pkg::*;
#(
  parameter int unsigned ENTRIES = BTB_ENTRIES,
  parameter int unsigned IDX_W   = BTB_IDX_W,
  parameter int unsigned TAG_W   = 30 - BTB_IDX_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] pc_pre,
  output logic            btb_en,
  output logic            btb_hit,
  output logic [1:0]      btb_cnt,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            btb_clr
);

  logic            valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q  [ENTRIES];
  logic [XLEN-1:0] tgt_q   [ENTRIES];
  logic [1:0]      cnt_q   [ENTRIES];

  logic [IDX_W-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             hit, uhit;
  logic [1:0]       cnt_next;

  // Byte offset within a 32-bit instruction word never selects an entry.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{if_pc[1:0], upd_pc[1:0]};

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[XLEN-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[XLEN-1:IDX_W+2];

  always_comb begin
    hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pc_pre  = hit ? tgt_q[if_idx] : '0;
    btb_cnt = hit ? cnt_q[if_idx] : 2'b00;
    btb_en  = hit && cnt_q[if_idx][1];
    btb_hit = hit;
  end

  assign uhit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  sat_cnt2 u_sat_cnt2 (
    .cnt      (cnt_q[upd_idx]),
    .up       (upd_taken),
    .cnt_next (cnt_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= CNT_WNT;
      end
    end else if (btb_clr) begin
      // Flush drops any coincident update; counters and targets are kept.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_valid) begin
      if (uhit) begin
        cnt_q[upd_idx] <= cnt_next;
        if (upd_taken) tgt_q[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
        tgt_q[upd_idx]   <= upd_target;
        cnt_q[upd_idx]   <= CNT_WT;
      end
    end
  end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- Looks up the current fetch PC in the IF stage and produces the predicted target and prediction enable for the next-PC select mux.
- Resolved branch and jump outcomes from EX train the table. This block is the direct upstream source of the next-PC mux's predicted-PC and BTB-enable inputs.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 4..64.
- IDX_W, 4, index width; must equal log2(ENTRIES).
- TAG_W, 26, tag width; must equal 30-IDX_W and covers pc[31:IDX_W+2].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  32  current fetch PC used for lookup.
- pc_pre  out  32  predicted target; 32'h0 on a miss.
- btb_en  out  1  prediction valid: hit AND counter[1]==1.
- btb_hit  out  1  tag hit, regardless of direction.
- btb_cnt  out  2  counter of the hit entry; 2'b00 on a miss. Pipelined by the core to EX for misprediction checks.
- upd_valid  in  1  EX resolution strobe, one cycle per resolved control instruction.
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  actual direction; jumps always 1.
- upd_target  in  32  actual target address.
- btb_clr  in  1  synchronous invalidate of all entries (fence.i / context flush).

Behaviour:
- Storage per entry: valid (1), tag (TAG_W), target (32), cnt (2). Held in flops, not block RAM.
- Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2]. pc[1:0] is ignored.
- Lookup is purely combinational from if_pc and the current table state (zero latency), so the mux sees the prediction in the same cycle as the fetch.
- hit = valid[idx] && tag[idx]==if_tag.
- pc_pre = hit ? target[idx] : 0.
- btb_cnt = hit ? cnt[idx] : 0.
- btb_en = hit && cnt[idx][1].
- Update is registered and takes effect on the rising edge after upd_valid. Let uhit = valid[uidx] && tag[uidx]==upd_tag.
  - uhit && upd_taken: cnt saturating increment (max 2'b11); target <= upd_target.
  - uhit && !upd_taken: cnt saturating decrement (min 2'b00); target unchanged; entry stays valid.
  - !uhit && upd_taken: allocate by overwriting the entry (replaces any conflicting tag); valid<=1, tag<=upd_tag, target<=upd_target, cnt<=2'b10 (weakly taken).
  - !uhit && !upd_taken: no state change; not-taken branches are never allocated.
- Simultaneous lookup and update to the same index: the lookup returns pre-update state, with no write-to-read bypass. The new state is visible from the next cycle.
- btb_clr: on the next edge, all valid bits go to 0; counters and targets are left unchanged. btb_clr has priority over a coincident upd_valid, which is dropped.
- Reset (rst_n low, asynchronous): all valid bits 0, all cnt 2'b01, all target 0, all tag 0.
  - Outputs during and after reset: btb_en=0, btb_hit=0, pc_pre=0, btb_cnt=0.
  - Reset asserted mid-operation discards all trained state immediately.
- No internal stall handling: the caller holds if_pc stable during a stall. Lookup is idempotent.
- Repeated upd_valid in back-to-back cycles to the same index must chain correctly; each update sees the previous edge's result.
- X-safety: when upd_valid=0, the upd_* inputs are don't-care and must not affect state.

Decomposition:
- Shared package (cpu_pkg): BTB_ENTRIES, BTB_IDX_W, counter encodings (SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11), and the XLEN=32 constant.
- One natural sub-module: sat_cnt2, a combinational 2-bit saturating up/down next-state function, instantiated once in the update path.
- Table storage and lookup/update stay in btb_predictor.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with if_pc=0x100 -> btb_hit=0, btb_en=0, pc_pre=0, btb_cnt=0. Release reset -> outputs stay 0.
- Allocate on taken: update upd_pc=0x100, taken=1, target=0x200. Next cycle if_pc=0x100 -> btb_hit=1, btb_cnt=2'b10, btb_en=1, pc_pre=0x200.
- Counter saturation and hysteresis:
  - From WT, three not-taken updates at 0x100 -> cnt 01, 00, 00; btb_en=0 after the first, btb_hit stays 1.
  - Then two taken updates -> cnt 01, then 10; btb_en returns to 1.
- Alias and not-taken allocation:
  - Entry for 0x100 valid; not-taken update at 0x140 (same index, different tag) -> no change, and lookup 0x100 still hits.
  - Then taken update at 0x140 with target 0x300 -> lookup 0x100 misses; lookup 0x140 hits with pc_pre=0x300.
- Same-cycle collision: if_pc=0x100 while an update to 0x100 with taken=1, target=0x400 is applied -> that cycle pc_pre=0x200; the next cycle pc_pre=0x400.
- Clear priority: btb_clr=1 in the same cycle as upd_valid=1 for 0x180 taken -> next cycle lookups of 0x100 and 0x180 both miss. Also assert rst_n low mid-run -> outputs drop to 0 asynchronously, before the next clock edge.
